pipeline_hazard_ctrl: RTL

- Control-side counterpart of the IF/ID, ID/EX, EX/DM and DM/WB pipeline registers in the 5-stage core.
- Consumes the stage-register fields (dest regs, write enables, load flag, branch/halt/busy) and drives each register's en, stall and active-low clr, plus PC enable.
- Generates ID-stage forwarding selects that are captured into ID/EX.
- Owns the halt/resume FSM and saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 39 +++
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and halt/resume FSM state codes.
package pipeline_hazard_ctrl_pkg;

  localparam int FWD_SEL_BIT = 2;

  localparam logic [FWD_SEL_BIT-1:0] FWD_RF = 2'd0;
  localparam logic [FWD_SEL_BIT-1:0] FWD_EX = 2'd1;
  localparam logic [FWD_SEL_BIT-1:0] FWD_DM = 2'd2;

  typedef enum logic [1:0] {
    HZ_RUN    = 2'd0,
    HZ_HALTED = 2'd1,
    HZ_RESUME = 2'd2
  } hz_state_e;

  // Forwarding select for one ID source; EX outranks DM, r0 never forwards.
  function automatic logic [FWD_SEL_BIT-1:0] fwd_pick(
    input logic       use_src,
    input logic [4:0] req,
    input logic       ex_w_en,
    input logic       ex_is_load,
    input logic [4:0] ex_req_w,
    input logic       dm_w_en,
    input logic [4:0] dm_req_w
  );
    logic [FWD_SEL_BIT-1:0] sel;
    sel = FWD_RF;
    if (use_src && (req != 5'd0) && ex_w_en && !ex_is_load && (ex_req_w == req)) begin
      sel = FWD_EX;
    end else if (use_src && (req != 5'd0) && dm_w_en && (dm_req_w == req)) begin
      sel = FWD_DM;
    end else begin
      sel = FWD_RF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall and flush performance counters.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] q
);

  logic [W-1:0] cnt_r;

  // Count up on inc, holding at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {W{1'b0}};
    end else if (inc && (cnt_r != {W{1'b1}})) begin
      cnt_r <= cnt_r + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign q = cnt_r;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stage-register control for the 5-stage core: stall/flush/freeze decisions,
// ID-stage forwarding selects, halt/resume FSM and performance counters.
module pipeline_hazard_ctrl
  import pipeline_hazard_ctrl_pkg::*;
#(
  parameter int CNT_W     = 32,
  parameter int FWD_SEL_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4:0]           id_req_a,
  input  logic [4:0]           id_req_b,
  input  logic                 id_use_a,
  input  logic                 id_use_b,
  input  logic                 id_jump,
  input  logic [4:0]           ex_req_w,
  input  logic                 ex_w_en,
  input  logic                 ex_is_load,
  input  logic                 ex_branch_taken,
  input  logic [4:0]           dm_req_w,
  input  logic                 dm_w_en,
  input  logic                 mem_busy,
  input  logic                 wb_halt,
  input  logic                 resume,
  output logic                 pc_en,
  output logic                 if_id_en,
  output logic                 if_id_stall,
  output logic                 if_id_clr_n,
  output logic                 id_ex_en,
  output logic                 id_ex_clr_n,
  output logic                 ex_dm_en,
  output logic                 ex_dm_clr_n,
  output logic                 dm_wb_en,
  output logic                 dm_wb_clr_n,
  output logic [FWD_SEL_W-1:0] fwd_a_sel,
  output logic [FWD_SEL_W-1:0] fwd_b_sel,
  output logic                 halted,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  hz_state_e state_r;
  hz_state_e state_nxt_s;
  logic      resume_q_r;
  logic      resume_rise_s;
  logic      load_use_s;
  logic      freeze_s;
  logic      stall_inc_s;
  logic      flush_inc_s;
  logic [FWD_SEL_BIT-1:0] sel_a_s;
  logic [FWD_SEL_BIT-1:0] sel_b_s;

  assign resume_rise_s = resume & ~resume_q_r;

  assign load_use_s = ex_is_load & ex_w_en & (ex_req_w != 5'd0) &
                      ((id_use_a & (id_req_a == ex_req_w)) |
                       (id_use_b & (id_req_b == ex_req_w)));

  // RESUME deliberately ignores wb_halt so the halt instruction can drain.
  assign freeze_s = (state_r == HZ_HALTED) || ((state_r == HZ_RUN) && wb_halt) || mem_busy;

  // FSM state and resume edge-detect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= HZ_RUN;
      resume_q_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      resume_q_r <= resume;
    end
  end

  // Next-state logic for the halt/resume FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      HZ_RUN: begin
        if (wb_halt && !mem_busy) begin
          state_nxt_s = HZ_HALTED;
        end else begin
          state_nxt_s = HZ_RUN;
        end
      end
      HZ_HALTED: begin
        if (resume_rise_s) begin
          state_nxt_s = HZ_RESUME;
        end else begin
          state_nxt_s = HZ_HALTED;
        end
      end
      HZ_RESUME: state_nxt_s = HZ_RUN;
      default:   state_nxt_s = HZ_RUN;
    endcase
  end

  // Prioritised stage-register control and counter increments.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_stall = 1'b0;
    if_id_clr_n = 1'b1;
    id_ex_en    = 1'b1;
    id_ex_clr_n = 1'b1;
    ex_dm_en    = 1'b1;
    ex_dm_clr_n = 1'b1;
    dm_wb_en    = 1'b1;
    dm_wb_clr_n = 1'b1;
    stall_inc_s = 1'b0;
    flush_inc_s = 1'b0;
    if (freeze_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_stall = 1'b1;
      id_ex_en    = 1'b0;
      ex_dm_en    = 1'b0;
      dm_wb_en    = 1'b0;
    end else if (ex_branch_taken) begin
      // ID holds a wrong-path instruction, so a branch beats load-use.
      if_id_clr_n = 1'b0;
      id_ex_clr_n = 1'b0;
      flush_inc_s = 1'b1;
    end else if (load_use_s) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_stall = 1'b1;
      id_ex_clr_n = 1'b0;
      stall_inc_s = 1'b1;
    end else if (id_jump) begin
      if_id_clr_n = 1'b0;
    end else begin
      pc_en = 1'b1;
    end
  end

  assign sel_a_s = fwd_pick(id_use_a, id_req_a, ex_w_en, ex_is_load, ex_req_w, dm_w_en, dm_req_w);
  assign sel_b_s = fwd_pick(id_use_b, id_req_b, ex_w_en, ex_is_load, ex_req_w, dm_w_en, dm_req_w);

  assign fwd_a_sel = FWD_SEL_W'(sel_a_s);
  assign fwd_b_sel = FWD_SEL_W'(sel_b_s);
  assign halted    = (state_r == HZ_HALTED);

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc_s),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc_s),
    .q     (flush_cnt)
  );

endmodule
